qspi_master: RTL and testbench
==============================

Name: qspi_master

Overview:
- Quad-SPI initiator that drives the QSS/QCK/QD[3:0] link, the other end of the QSPI analog responder that talks to the STM32 co-processor.
- Lets the Murax SoC, or a bench/second FPGA, issue register writes and reads over the same framing the responder consumes.
- Command/response stream interface on the core side; tri-state pad signals on the pin side, for SB_IO instances in the toplevel.

Parameters:
- CLK_DIV, 2, main-clock cycles per QCK half-period; legal range >= 1.
- DUMMY_CYCLES, 2, QCK turnaround cycles between header and read data; legal range >= 0.

Ports:
- io_mainClk  in  1  system clock.
- io_asyncReset  in  1  reset, asynchronous and active-high.
- io_cmd_valid  in  1  command request.
- io_cmd_ready  out  1  high only in IDLE; accept = valid && ready.
- io_cmd_payload_read  in  1  1 = read frame, 0 = write frame.
- io_cmd_payload_addr  in  7  register address.
- io_cmd_payload_data  in  32  write data; ignored for reads.
- io_rsp_valid  out  1  one-cycle pulse when read data is complete.
- io_rsp_payload  out  32  read data; held until the next read completes.
- io_busy  out  1  high whenever state != IDLE.
- io_qss  out  1  chip select, active low.
- io_qck  out  1  serial clock, mode 0 (idles low).
- io_qd_write  out  4  QD output data.
- io_qd_writeEnable  out  4  per-pin output enable; all bits always equal.
- io_qd_read  in  4  QD input data.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame): state IDLE, io_qss=1, io_qck=0, io_qd_write=0, io_qd_writeEnable=0, io_rsp_valid=0, io_rsp_payload=0, io_cmd_ready=1, io_busy=0. An aborted frame produces no response.
- Command capture: all payload fields are registered at accept. Header byte = {read, addr[6:0]}.
- Frame structure:
  - A frame is a sequence of QCK cycles; each cycle is a low phase of CLK_DIV clocks followed by a high phase of CLK_DIV clocks.
  - Each nibble is driven for its whole QCK cycle and updates on the cycle that QCK falls; the responder samples on the QCK rising edge.
- States:
  - IDLE: waits for accept.
  - HEADER: 2 QCK cycles, header[7:4] then header[3:0]; writeEnable=F.
  - TURN: read only, DUMMY_CYCLES QCK cycles; writeEnable=0, write=0. Skipped when DUMMY_CYCLES=0.
  - DATA: 8 QCK cycles, data[31:28] first, MSB nibble first.
    - Write: drive the data nibbles with writeEnable=F.
    - Read: writeEnable=0; capture io_qd_read on the last main-clock cycle of each high phase; shift left by 4.
  - TRAIL: QCK low, QSS still low, CLK_DIV clocks; writeEnable=0.
  - GAP: QSS high, QCK low, 2*CLK_DIV clocks; then IDLE.
- Timing, with accept in cycle T:
  - QSS falls and nibble 0 appears at T+1.
  - Total QCK cycles N = 10 for a write, 10+DUMMY_CYCLES for a read.
  - QSS rises at T+1+(2N+1)*CLK_DIV.
  - io_cmd_ready is high again at T+1+(2N+3)*CLK_DIV.
- Response: for a read, io_rsp_valid pulses for one cycle on the first GAP cycle, with io_rsp_payload already updated in that cycle. Writes never pulse io_rsp_valid.
- Timing counters:
  - Half-period counter counts 0..CLK_DIV-1; QCK toggles on wrap.
  - QCK-cycle counter width is sized for 10+DUMMY_CYCLES.
  - No glitches on QSS/QCK; all pad outputs are registered.
- Boundary and illegal-input cases:
  - io_cmd_valid held high in IDLE: back-to-back frames, still separated by a full GAP.
  - Command inputs changing while busy: ignored.
  - io_qd_read outside the capture cycles: ignored.
  - CLK_DIV=1: QCK = main clock / 2, every phase exactly 1 clock.

Test Plan:
- Write, CLK_DIV=2: addr=0x15, data=0xDEADBEEF, accept at T.
  - QSS falls at T+1.
  - Nibbles on QCK rising edges: 1,5,D,E,A,D,B,E,E,F.
  - writeEnable=F throughout; QSS rises at T+43; ready at T+47; no rsp_valid.
- Read, CLK_DIV=2, DUMMY_CYCLES=2: addr=0x7F. Bench responder drives 0x12345678 during DATA.
  - Header nibbles F,F; writeEnable=0 from the first TURN cycle.
  - rsp_valid pulses once with payload 0x12345678; ready at T+55.
- Back-to-back: valid held high with a write then a read.
  - QSS high for exactly 4 clocks between frames; second accept at T+47.
  - Read response correct; ready is low for the whole of both frames.
- Reset mid-frame: assert io_asyncReset during DATA of a read.
  - Same cycle: QSS=1, QCK=0, writeEnable=0.
  - No rsp_valid; after release, ready=1 and a new write frame is correct.
- CLK_DIV=1, DUMMY_CYCLES=0 read: responder returns 0xA5A5A5A5.
  - QCK toggles every clock; TURN is skipped.
  - DATA starts right after header nibble 1; payload=0xA5A5A5A5; ready at T+1+23.
- Idle hold: no valid for 100 cycles.
  - QSS=1, QCK=0, writeEnable=0, busy=0, rsp_payload unchanged.

Source files
------------

// File: rtl/qspi_master.sv
// Quad-SPI initiator: turns one command (register write or read) into a framed
// QSS/QCK/QD[3:0] transfer and returns read data as a one-cycle response pulse.
module qspi_master #(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 2
) (
  input  logic        io_mainClk,
  input  logic        io_asyncReset,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic        io_cmd_payload_read,
  input  logic [6:0]  io_cmd_payload_addr,
  input  logic [31:0] io_cmd_payload_data,
  output logic        io_rsp_valid,
  output logic [31:0] io_rsp_payload,
  output logic        io_busy,
  output logic        io_qss,
  output logic        io_qck,
  output logic [3:0]  io_qd_write,
  output logic [3:0]  io_qd_writeEnable,
  input  logic [3:0]  io_qd_read,
  output logic [2:0]  dbg_state_o
);

  // Command handshake: a command is accepted in any cycle where io_cmd_valid
  // and io_cmd_ready are both high; ready is high exactly while the FSM is idle.

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CYC_W = $clog2(10 + DUMMY_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CYC_W-1:0] HDR_LAST  = CYC_W'(1);
  localparam logic [CYC_W-1:0] DATA_LAST = CYC_W'(7);
  localparam logic [CYC_W-1:0] TURN_LAST = CYC_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_TURN,
    ST_DATA,
    ST_TRAIL,
    ST_GAP
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [CYC_W-1:0] cyc_q;
  logic             qck_q;
  logic             qss_q;
  logic [3:0]       qd_q;
  logic             oe_q;
  logic             rd_q;
  logic [3:0]       hdr_lo_q;
  logic [31:0]      sh_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_q;

  logic phase_end;

  assign phase_end = (div_q == DIV_LAST);

  assign io_cmd_ready      = (state_q == ST_IDLE);
  assign io_busy           = (state_q != ST_IDLE);
  assign io_qss            = qss_q;
  assign io_qck            = qck_q;
  assign io_qd_write       = qd_q;
  assign io_qd_writeEnable = {4{oe_q}};
  assign io_rsp_valid      = rsp_valid_q;
  assign io_rsp_payload    = rsp_q;
  assign dbg_state_o       = state_q;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      cyc_q       <= '0;
      qck_q       <= 1'b0;
      qss_q       <= 1'b1;
      qd_q        <= 4'h0;
      oe_q        <= 1'b0;
      rd_q        <= 1'b0;
      hdr_lo_q    <= 4'h0;
      sh_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q != ST_IDLE) begin
        div_q <= phase_end ? '0 : div_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (io_cmd_valid) begin
            state_q  <= ST_HEADER;
            rd_q     <= io_cmd_payload_read;
            hdr_lo_q <= io_cmd_payload_addr[3:0];
            sh_q     <= io_cmd_payload_read ? 32'h0 : io_cmd_payload_data;
            qss_q    <= 1'b0;
            qck_q    <= 1'b0;
            qd_q     <= {io_cmd_payload_read, io_cmd_payload_addr[6:4]};
            oe_q     <= 1'b1;
            cyc_q    <= '0;
            div_q    <= '0;
          end
        end

        ST_HEADER: begin
          if (phase_end) begin
            if (!qck_q) begin
              qck_q <= 1'b1;
            end else begin
              qck_q <= 1'b0;
              if (cyc_q == HDR_LAST) begin
                cyc_q <= '0;
                if (rd_q && (DUMMY_CYCLES > 0)) begin
                  state_q <= ST_TURN;
                  qd_q    <= 4'h0;
                  oe_q    <= 1'b0;
                end else if (rd_q) begin
                  state_q <= ST_DATA;
                  qd_q    <= 4'h0;
                  oe_q    <= 1'b0;
                end else begin
                  state_q <= ST_DATA;
                  qd_q    <= sh_q[31:28];
                  sh_q    <= {sh_q[27:0], 4'h0};
                end
              end else begin
                cyc_q <= cyc_q + 1'b1;
                qd_q  <= hdr_lo_q;
              end
            end
          end
        end

        // Bus released for the responder to turn the pins around.
        ST_TURN: begin
          if (phase_end) begin
            if (!qck_q) begin
              qck_q <= 1'b1;
            end else begin
              qck_q <= 1'b0;
              if (cyc_q == TURN_LAST) begin
                state_q <= ST_DATA;
                cyc_q   <= '0;
              end else begin
                cyc_q <= cyc_q + 1'b1;
              end
            end
          end
        end

        ST_DATA: begin
          if (phase_end) begin
            if (!qck_q) begin
              qck_q <= 1'b1;
            end else begin
              qck_q <= 1'b0;
              // Read data is taken on the last clock of the high phase only.
              if (rd_q) begin
                sh_q <= {sh_q[27:0], io_qd_read};
              end
              if (cyc_q == DATA_LAST) begin
                state_q <= ST_TRAIL;
                qd_q    <= 4'h0;
                oe_q    <= 1'b0;
              end else begin
                cyc_q <= cyc_q + 1'b1;
                if (!rd_q) begin
                  qd_q <= sh_q[31:28];
                  sh_q <= {sh_q[27:0], 4'h0};
                end
              end
            end
          end
        end

        ST_TRAIL: begin
          if (phase_end) begin
            state_q <= ST_GAP;
            qss_q   <= 1'b1;
            cyc_q   <= '0;
            if (rd_q) begin
              rsp_valid_q <= 1'b1;
              rsp_q       <= sh_q;
            end
          end
        end

        // Two half-periods with QSS high before the next frame may start.
        ST_GAP: begin
          if (phase_end) begin
            if (cyc_q == HDR_LAST) begin
              state_q <= ST_IDLE;
              cyc_q   <= '0;
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          qss_q   <= 1'b1;
          qck_q   <= 1'b0;
          oe_q    <= 1'b0;
          qd_q    <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_master.sv
// Bench for qspi_master: two instances (CLK_DIV=2/DUMMY=2 and CLK_DIV=1/DUMMY=0),
// cycle-exact frame checks plus nibble and response scoreboards.
module tb_qspi_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        cmd_valid   [2];
  logic        cmd_ready   [2];
  logic        cmd_read    [2];
  logic [6:0]  cmd_addr    [2];
  logic [31:0] cmd_data    [2];
  logic        rsp_valid   [2];
  logic [31:0] rsp_payload [2];
  logic        busy        [2];
  logic        qss         [2];
  logic        qck         [2];
  logic [3:0]  qd_w        [2];
  logic [3:0]  qd_oe       [2];
  logic [3:0]  qd_r        [2];
  logic [2:0]  dbg         [2];

  qspi_master #(.CLK_DIV(2), .DUMMY_CYCLES(2)) dut0 (
    .io_mainClk(clk), .io_asyncReset(rst),
    .io_cmd_valid(cmd_valid[0]), .io_cmd_ready(cmd_ready[0]),
    .io_cmd_payload_read(cmd_read[0]), .io_cmd_payload_addr(cmd_addr[0]),
    .io_cmd_payload_data(cmd_data[0]),
    .io_rsp_valid(rsp_valid[0]), .io_rsp_payload(rsp_payload[0]),
    .io_busy(busy[0]), .io_qss(qss[0]), .io_qck(qck[0]),
    .io_qd_write(qd_w[0]), .io_qd_writeEnable(qd_oe[0]), .io_qd_read(qd_r[0]),
    .dbg_state_o(dbg[0])
  );

  qspi_master #(.CLK_DIV(1), .DUMMY_CYCLES(0)) dut1 (
    .io_mainClk(clk), .io_asyncReset(rst),
    .io_cmd_valid(cmd_valid[1]), .io_cmd_ready(cmd_ready[1]),
    .io_cmd_payload_read(cmd_read[1]), .io_cmd_payload_addr(cmd_addr[1]),
    .io_cmd_payload_data(cmd_data[1]),
    .io_rsp_valid(rsp_valid[1]), .io_rsp_payload(rsp_payload[1]),
    .io_busy(busy[1]), .io_qss(qss[1]), .io_qck(qck[1]),
    .io_qd_write(qd_w[1]), .io_qd_writeEnable(qd_oe[1]), .io_qd_read(qd_r[1]),
    .dbg_state_o(dbg[1])
  );

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int act   = 0;
  logic [3:0]  nib_exp_q[$];
  logic [31:0] rsp_exp_q[$];
  logic [31:0] last_payload [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Driven nibbles are taken at each QCK rising edge; responses when rsp_valid pulses.
  logic prev_qck = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (qck[act] && !prev_qck && qd_oe[act] == 4'hF) begin
        if (nib_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL nib_extra: got=%h want=none", qd_w[act]);
        end else begin
          check("nibble", qd_w[act], nib_exp_q.pop_front());
        end
      end
      if (rsp_valid[act]) begin
        if (rsp_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_extra: got=%h want=none", rsp_payload[act]);
        end else begin
          check("rsp_payload", rsp_payload[act], rsp_exp_q.pop_front());
        end
      end
    end
    prev_qck = qck[act];
  end

  // ---------------- driver ----------------
  task automatic frame(input int d, input bit rd, input logic [6:0] addr,
                       input logic [7:0] exp_hdr, input logic [31:0] wdata,
                       input logic [31:0] resp, input bit hold, input int abort_at,
                       output int t_acc);
    int cd, dc, n, k_end, c, j;
    logic e_qss, e_qck, e_rv;
    logic [3:0] e_oe, got_qd;
    cd = (d == 0) ? 2 : 1;
    dc = (d == 0) ? 2 : 0;
    n = rd ? 10 + dc : 10;
    k_end = (2 * n + 3) * cd;
    act = d;
    @(negedge clk);
    check($sformatf("idle_pre_d%0d", d),
          {cmd_ready[d], busy[d], qss[d], qck[d], qd_oe[d]},
          {1'b1, 1'b0, 1'b1, 1'b0, 4'h0});
    cmd_valid[d] = 1'b1;
    cmd_read[d]  = rd;
    cmd_addr[d]  = addr;
    cmd_data[d]  = wdata;
    t_acc = cyc_n;
    nib_exp_q.push_back(exp_hdr[7:4]);
    nib_exp_q.push_back(exp_hdr[3:0]);
    if (!rd) begin
      for (int i = 0; i < 8; i++) nib_exp_q.push_back(wdata[31 - 4 * i -: 4]);
    end else if (abort_at < 0) begin
      rsp_exp_q.push_back(resp);
    end
    for (int k = 0; k < k_end; k++) begin
      @(negedge clk);
      if (!hold) cmd_valid[d] = 1'b0;
      cmd_read[d] = 1'($urandom);
      cmd_addr[d] = 7'($urandom);
      cmd_data[d] = $urandom;
      c = k / (2 * cd);
      if (abort_at == k) begin
        rst = 1'b1;
        #1;
        check("abort_outputs",
              {qss[d], qck[d], qd_oe[d], cmd_ready[d], busy[d], rsp_valid[d], rsp_payload[d]},
              {1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0});
        nib_exp_q.delete();
        rsp_exp_q.delete();
        last_payload[0] = '0;
        last_payload[1] = '0;
        cmd_valid[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k < 2 * n * cd) begin
        e_qss = 1'b0;
        e_qck = ((k % (2 * cd)) >= cd);
        e_oe  = (c < 2 || !rd) ? 4'hF : 4'h0;
      end else if (k < (2 * n + 1) * cd) begin
        e_qss = 1'b0; e_qck = 1'b0; e_oe = 4'h0;
      end else begin
        e_qss = 1'b1; e_qck = 1'b0; e_oe = 4'h0;
      end
      e_rv = rd && (k == (2 * n + 1) * cd);
      got_qd = (e_oe == 4'h0) ? qd_w[d] : 4'h0;
      check($sformatf("frame_d%0d_k%0d", d, k),
            {qss[d], qck[d], qd_oe[d], got_qd, cmd_ready[d], busy[d], rsp_valid[d]},
            {e_qss, e_qck, e_oe, 4'h0, 1'b0, 1'b1, e_rv});
      // Correct nibble only on the capture clock; noise everywhere else.
      if (rd && c >= 2 + dc && c < n && (k % (2 * cd)) == 2 * cd - 1) begin
        j = c - 2 - dc;
        qd_r[d] = resp[31 - 4 * j -: 4];
      end else begin
        qd_r[d] = 4'($urandom);
      end
    end
    if (rd) last_payload[d] = resp;
  endtask

  // ---------------- test ----------------
  typedef struct {
    int          d;
    bit          rd;
    logic [6:0]  addr;
    logic [7:0]  hdr;
    logic [31:0] wdata;
    logic [31:0] resp;
  } vec_t;

  vec_t vecs [6];
  int t1, t2, t3;

  initial begin
    vecs[0] = '{0, 1'b0, 7'h15, 8'h15, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 1'b1, 7'h7F, 8'hFF, 32'h0,        32'h12345678};
    vecs[2] = '{0, 1'b1, 7'h2A, 8'hAA, 32'hFFFF0000, 32'h0F0F1234};
    vecs[3] = '{0, 1'b0, 7'h00, 8'h00, 32'h00000001, 32'h0};
    vecs[4] = '{1, 1'b1, 7'h33, 8'hB3, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1, 1'b0, 7'h41, 8'h41, 32'h89ABCDEF, 32'h0};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_read[i] = 1'b0; cmd_addr[i] = '0;
      cmd_data[i] = '0; qd_r[i] = '0; last_payload[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_d%0d", i),
            {qss[i], qck[i], qd_w[i], qd_oe[i], rsp_valid[i], rsp_payload[i], cmd_ready[i], busy[i]},
            {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0});
    end
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      frame(vecs[v].d, vecs[v].rd, vecs[v].addr, vecs[v].hdr, vecs[v].wdata,
            vecs[v].resp, 1'b0, -1, t1);
    end

    // Back-to-back with valid held high: second accept exactly 47 clocks later.
    frame(0, 1'b0, 7'h10, 8'h10, 32'h0BADF00D, 32'h0, 1'b1, -1, t1);
    frame(0, 1'b1, 7'h05, 8'h85, 32'h0, 32'hCAFEF00D, 1'b0, -1, t2);
    check("b2b_accept_gap", 64'(t2 - t1), 64'd47);

    // Reset during DATA of a read (QCK cycle 7), then a clean write.
    frame(0, 1'b1, 7'h7F, 8'hFF, 32'h0, 32'h11112222, 1'b0, 29, t3);
    frame(0, 1'b0, 7'h15, 8'h15, 32'hDEADBEEF, 32'h0, 1'b0, -1, t3);
    frame(0, 1'b1, 7'h7F, 8'hFF, 32'h0, 32'h12345678, 1'b0, -1, t3);

    // Long idle with noise on QD inputs.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      qd_r[0] = 4'($urandom);
      qd_r[1] = 4'($urandom);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("idle_hold_d%0d_%0d", i, k),
              {qss[i], qck[i], qd_oe[i], busy[i], rsp_valid[i], rsp_payload[i]},
              {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, last_payload[i]});
      end
    end

    check("nib_queue_drained", 64'(nib_exp_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(rsp_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
